// File: rtl/enum_update_writer.sv
// Two-stage enum-indexed array writer: stage 0 captures sel/data, stage 1 commits to a
// 4-element register array with bounds checking, drop pulse and saturating drop counter.
module enum_update_writer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          sel,
  input  logic [DATA_W-1:0]   data,
  input  logic                clear,
  output logic [4*DATA_W-1:0] arr,
  output logic                wr_ack,
  output logic                oob_drop,
  output logic [CNT_W-1:0]    drop_count
);

  logic                p0_valid_q, p0_valid_d;
  logic [2:0]          p0_idx_q, p0_idx_d;
  logic [DATA_W-1:0]   p0_data_q, p0_data_d;
  logic [4*DATA_W-1:0] arr_q, arr_d;
  logic                wr_ack_q, wr_ack_d;
  logic                oob_drop_q, oob_drop_d;
  logic [CNT_W-1:0]    drop_count_q, drop_count_d;

  assign in_ready = !clear;

  // Index is kept at 3 bits so sel=3 lands on 4 and is caught by the range check
  // rather than silently wrapping onto element 0.
  always_comb begin
    p0_valid_d   = in_valid && in_ready;
    p0_idx_d     = {1'b0, sel} + 3'd1;
    p0_data_d    = data;
    arr_d        = arr_q;
    wr_ack_d     = 1'b0;
    oob_drop_d   = 1'b0;
    drop_count_d = drop_count_q;
    if (clear) begin
      arr_d = '0;
    end else if (p0_valid_q) begin
      if (p0_idx_q <= 3'd3) begin
        for (int i = 0; i < 4; i++) begin
          if (p0_idx_q[1:0] == i[1:0]) begin
            arr_d[DATA_W*i +: DATA_W] = p0_data_q;
          end
        end
        wr_ack_d = 1'b1;
      end else begin
        oob_drop_d = 1'b1;
        if (drop_count_q != '1) begin
          drop_count_d = drop_count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_valid_q   <= 1'b0;
      p0_idx_q     <= '0;
      p0_data_q    <= '0;
      arr_q        <= '0;
      wr_ack_q     <= 1'b0;
      oob_drop_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      p0_valid_q   <= p0_valid_d;
      p0_idx_q     <= p0_idx_d;
      p0_data_q    <= p0_data_d;
      arr_q        <= arr_d;
      wr_ack_q     <= wr_ack_d;
      oob_drop_q   <= oob_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign arr        = arr_q;
  assign wr_ack     = wr_ack_q;
  assign oob_drop   = oob_drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/enum_update_writer.md
ENUM_UPDATE_WRITER -- requirements
Module: enum_update_writer

Interface
REQ-001 Parameter DATA_W, default 32: element width in bits.
REQ-002 Parameter CNT_W, default 8: width of the dropped-write counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  write request present.
REQ-006 in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-007 sel  input  2  enum selector; target index = sel + 1.
REQ-008 data  input  DATA_W  element value to write.
REQ-009 clear  input  1  zero all array elements.
REQ-010 arr  output  4*DATA_W  registered array, flattened; element i at bits [DATA_W*i+DATA_W-1 : DATA_W*i].
REQ-011 wr_ack  output  1  one-cycle pulse: a write committed to arr.
REQ-012 oob_drop  output  1  one-cycle pulse: a write was discarded as out of bounds.
REQ-013 drop_count  output  CNT_W  saturating count of discarded writes.

Function
REQ-014 The block SHALL be a 2-stage write pipeline: stage 0 captures the request; stage 1 commits it to the array register.
REQ-015 On acceptance, stage 0 SHALL register p0_valid=1, p0_data=data, and p0_idx = {1'b0, sel} + 3'd1 computed at 3 bits (no truncation before the range check).
REQ-016 Without acceptance, p0_valid SHALL be 0 at the next edge.
REQ-017 in_ready SHALL equal !clear; no other backpressure exists.
REQ-018 With p0_valid=1 and p0_idx <= 3, the next edge SHALL write element p0_idx[1:0] to p0_data, leave the other elements unchanged, and assert wr_ack for exactly one cycle.
REQ-019 With p0_valid=1 and p0_idx > 3 (sel=3 only), the next edge SHALL leave arr unchanged, assert oob_drop for one cycle, and increment drop_count.
REQ-020 Out-of-bounds writes SHALL be dropped, never clamped.
REQ-021 Element 0 is not writable through this port.
REQ-022 drop_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 wr_ack and oob_drop SHALL never be asserted in the same cycle.
REQ-024 Latency: a request accepted at edge N SHALL be visible on arr after edge N+1; wr_ack or oob_drop SHALL be high in the cycle after edge N+1.
REQ-025 Back-to-back requests SHALL be accepted every cycle; throughput is 1 per cycle.
REQ-026 Consecutive writes to the same index SHALL resolve in acceptance order: the last one wins.
REQ-027 clear=1 at edge N SHALL set all elements to 0 at edge N.
REQ-028 clear=1 at edge N SHALL discard the stage-0 entry committing at that edge; no wr_ack, no oob_drop, and drop_count unchanged for it.
REQ-029 clear SHALL NOT reset drop_count.
REQ-030 arr and all outputs SHALL be driven from registers, except in_ready.

Reset
REQ-031 While rst=1 at an edge: arr=0, p0_valid=0, wr_ack=0, oob_drop=0, drop_count=0.
REQ-032 rst SHALL take priority over clear and over in-flight requests.
REQ-033 A request in stage 0 when rst asserts SHALL be lost, with no pulse.
REQ-034 in_ready SHALL follow REQ-017 during reset; requests presented during reset SHALL be ignored.

Verification
REQ-035 Reset then write sel=0 data=0xA5A5A5A5 -> two edges later arr[63:32]=0xA5A5A5A5, all other bits 0, wr_ack one-cycle pulse.
REQ-036 Writes on consecutive cycles sel=0,1,2 with data 1,2,3 -> arr = {3,2,1,0} (elements 3..0); three consecutive wr_ack cycles.
REQ-037 Write sel=3 data=0xFFFFFFFF -> arr unchanged, oob_drop pulses once, drop_count=1; after 260 such writes drop_count=255 (CNT_W=8).
REQ-038 Write sel=1 data=7, then clear in the following cycle -> arr=0, no wr_ack, in_ready=0 during the clear cycle.
REQ-039 Write sel=2 data=9 then sel=2 data=10 back-to-back -> element 3 ends at 10.
REQ-040 Accept write sel=0, assert rst next cycle -> arr=0, no wr_ack; drop_count=0 after rst deasserts.
